// File: rtl/seq_pattern_gen_if.sv
// Output stream of the pattern generator: data/valid toward the consumer
// and the consumer's ready back to the generator.
interface seq_pattern_gen_if #(
  parameter int DATA_W = 8
);
  logic              o_dv;
  logic [DATA_W-1:0] o_data;
  logic              o_ready;

  modport master (output o_dv, output o_data, input o_ready);
  modport slave  (input o_dv, input o_data, output o_ready);
endinterface

// File: rtl/seq_pattern_gen.sv
// Programmable data/valid pattern generator: plays a table of {data, dv} entries
// onto a ready/valid stream, with one-shot, loop and stop-request control.
module seq_pattern_gen #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_dv,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              stop,
  seq_pattern_gen_if.master stream,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              dv;
  } entry_t;

  entry_t            tbl [DEPTH];
  state_t            state_q, state_n;
  logic [ADDR_W-1:0] idx_q, idx_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic              loop_q, loop_n;
  logic              stop_pend_q, stop_pend_n;
  entry_t            out_q, out_n;
  logic              done_n;

  logic len_ok, advance, last, end_req;

  // NOTE: the table is cleared on reset so a run after reset plays defined gap
  // entries; this keeps it in flops rather than a RAM macro, which is fine at this size.
  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (cfg_we && state_q == IDLE) begin
      tbl[cfg_addr] <= '{data: cfg_data, dv: cfg_dv};
    end
  end

  assign len_ok  = (cfg_len != '0) && (cfg_len <= (ADDR_W+1)'(DEPTH));
  assign advance = !out_q.dv || stream.o_ready;
  assign last    = ({1'b0, idx_q} == len_q - (ADDR_W+1)'(1));
  assign end_req = stop_pend_q || stop;

  // NOTE: every variable gets its default first, so no path through the case
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    len_n       = len_q;
    loop_n      = loop_q;
    stop_pend_n = stop_pend_q;
    out_n       = out_q;
    done_n      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stop_pend_n = 1'b0;
        if (start && len_ok) begin
          state_n = RUN;
          len_n   = cfg_len;
          loop_n  = cfg_loop;
          idx_n   = '0;
          out_n   = tbl[0];
        end
      end
      RUN: begin
        if (advance) begin
          if (end_req || (last && !loop_q)) begin
            state_n     = IDLE;
            out_n       = '0;
            done_n      = 1'b1;
            stop_pend_n = 1'b0;
          end else if (last) begin
            idx_n = '0;
            out_n = tbl[0];
          end else begin
            idx_n = idx_q + ADDR_W'(1);
            out_n = tbl[idx_q + ADDR_W'(1)];
          end
        end else if (stop) begin
          // Beat still pending: remember the request, end on its acceptance.
          stop_pend_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      out_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      len_q       <= len_n;
      loop_q      <= loop_n;
      stop_pend_q <= stop_pend_n;
      out_q       <= out_n;
      busy        <= (state_n == RUN);
      done        <= done_n;
    end
  end

  assign stream.o_dv   = out_q.dv;
  assign stream.o_data = out_q.data;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_seq_pattern_gen;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              sclk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_dv;
  logic [ADDR_W:0]   cfg_len;
  logic              cfg_loop;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;

  seq_pattern_gen_if #(.DATA_W(DATA_W)) sif ();

  seq_pattern_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_dv   (cfg_dv),
    .cfg_len  (cfg_len),
    .cfg_loop (cfg_loop),
    .start    (start),
    .stop     (stop),
    .stream   (sif),
    .busy     (busy),
    .done     (done)
  );

  always #5 sclk = ~sclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic dv, input logic [7:0] data,
                            input logic bz, input logic dn);
    check({name, ".dv"},   sif.o_dv,   dv);
    check({name, ".data"}, sif.o_data, data);
    check({name, ".busy"}, busy,       bz);
    check({name, ".done"}, done,       dn);
  endtask

  task automatic cyc(input logic st, input logic rd, input logic sp);
    start = st; sif.o_ready = rd; stop = sp;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic v);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_dv = v;
    tick();
    cfg_we = 1'b0;
  endtask

  // Directed vectors: inputs during a cycle, outputs expected in the next cycle.
  typedef struct {
    logic       start;
    logic       ready;
    logic       exp_dv;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs [14];

  // Behavioural model: position k counts entries shown since start; the entry
  // shown is k mod len.
  logic [7:0] m_td [DEPTH];
  logic       m_tv [DEPTH];
  bit         m_run, m_loop, m_stop, m_dv, m_done;
  logic [7:0] m_data;
  int         m_len, m_k;

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_td[i] = '0; m_tv[i] = 1'b0; end
      m_run = 0; m_loop = 0; m_stop = 0; m_dv = 0; m_done = 0; m_data = '0;
      m_len = 0; m_k = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (start && cfg_len >= 1 && int'(cfg_len) <= DEPTH) begin
        m_run = 1; m_len = int'(cfg_len); m_loop = cfg_loop; m_k = 0; m_stop = 0;
        m_dv = m_tv[0]; m_data = m_td[0];
      end
      if (cfg_we) begin m_td[cfg_addr] = cfg_data; m_tv[cfg_addr] = cfg_dv; end
    end else begin
      m_done = 0;
      if (!m_dv || sif.o_ready) begin
        if (m_stop || stop || ((m_k % m_len) == m_len - 1 && !m_loop)) begin
          m_run = 0; m_dv = 0; m_data = '0; m_done = 1; m_stop = 0;
        end else begin
          m_k++;
          m_dv = m_tv[m_k % m_len]; m_data = m_td[m_k % m_len];
        end
      end else if (stop) begin
        m_stop = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_dv = 1'b0;
    cfg_len = 4'd3; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0; sif.o_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);

    write_entry(3'd0, 8'h07, 1'b1);
    write_entry(3'd1, 8'h00, 1'b0);
    write_entry(3'd2, 8'h05, 1'b1);

    // One-shot with ready high, then with ready held low over the first beat.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].start, vecs[i].ready, 1'b0);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_dv, vecs[i].exp_data,
                 vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Loop with stop arriving together with acceptance of entry 2.
    cfg_loop = 1'b1;
    cyc(1, 1, 0); expect_out("loop_c1", 1, 8'h07, 1, 0);
    cyc(0, 1, 0); expect_out("loop_c2", 0, 8'h00, 1, 0);
    cyc(0, 1, 0); expect_out("loop_c3", 1, 8'h05, 1, 0);
    cyc(0, 1, 0); expect_out("loop_c4", 1, 8'h07, 1, 0);
    cyc(0, 1, 0); expect_out("loop_c5", 0, 8'h00, 1, 0);
    cyc(0, 1, 0); expect_out("loop_c6", 1, 8'h05, 1, 0);
    cyc(0, 1, 1); expect_out("loop_stop", 0, 8'h00, 0, 1);
    cyc(0, 1, 0); expect_out("loop_after", 0, 8'h00, 0, 0);

    // Stop while a valid beat is stalled: beat must complete first.
    cyc(1, 0, 0); expect_out("stall_c1", 1, 8'h07, 1, 0);
    cyc(0, 0, 1); expect_out("stall_stop", 1, 8'h07, 1, 0);
    cyc(0, 0, 0); expect_out("stall_hold", 1, 8'h07, 1, 0);
    cyc(0, 1, 0); expect_out("stall_end", 0, 8'h00, 0, 1);
    cyc(0, 1, 0); expect_out("stall_after", 0, 8'h00, 0, 0);

    // Illegal lengths are ignored; table writes during RUN are ignored.
    cfg_loop = 1'b0;
    cfg_len = 4'd0; cyc(1, 1, 0); expect_out("len0", 0, 8'h00, 0, 0);
    cfg_len = 4'd9; cyc(1, 1, 0); expect_out("len9", 0, 8'h00, 0, 0);
    cfg_len = 4'd3; cyc(1, 0, 0); expect_out("we_run_c1", 1, 8'h07, 1, 0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'hAA; cfg_dv = 1'b1;
    cyc(0, 0, 0); expect_out("we_run_hold", 1, 8'h07, 1, 0);
    cfg_we = 1'b0;
    cyc(0, 1, 0); expect_out("we_run_gap", 0, 8'h00, 1, 0);
    cyc(0, 1, 0); expect_out("we_run_e2", 1, 8'h05, 1, 0);
    cyc(0, 1, 0); expect_out("we_run_done", 0, 8'h00, 0, 1);
    cyc(1, 1, 0); expect_out("readback_e0", 1, 8'h07, 1, 0);
    cyc(0, 1, 0); expect_out("readback_e1", 0, 8'h00, 1, 0);
    cyc(0, 1, 0); expect_out("readback_e2", 1, 8'h05, 1, 0);
    cyc(0, 1, 0); expect_out("readback_done", 0, 8'h00, 0, 1);

    // Reset mid-run at idx 1, then the cleared table plays as gaps.
    cyc(1, 1, 0); expect_out("rst_c1", 1, 8'h07, 1, 0);
    cyc(0, 1, 0); expect_out("rst_c2", 0, 8'h00, 1, 0);
    rst = 1'b1;
    cyc(0, 1, 0); expect_out("rst_mid", 0, 8'h00, 0, 0);
    rst = 1'b0;
    cyc(1, 1, 0); expect_out("zero_e0", 0, 8'h00, 1, 0);
    cyc(0, 1, 0); expect_out("zero_e1", 0, 8'h00, 1, 0);
    cyc(0, 1, 0); expect_out("zero_e2", 0, 8'h00, 1, 0);
    cyc(0, 1, 0); expect_out("zero_done", 0, 8'h00, 0, 1);

    // Randomized traffic against the model, starting from a common reset.
    rst = 1'b1;
    model_step();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      cfg_we      = ($urandom_range(0, 2) == 0);
      cfg_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
      cfg_data    = 8'($urandom);
      cfg_dv      = ($urandom_range(0, 3) != 0);
      cfg_len     = 4'($urandom_range(0, DEPTH + 1));
      cfg_loop    = 1'($urandom);
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      sif.o_ready = ($urandom_range(0, 9) < 6);
      model_step();
      tick();
      check("rnd_dv",   sif.o_dv,   m_dv);
      check("rnd_data", sif.o_data, m_data);
      check("rnd_busy", busy,       m_run);
      check("rnd_done", done,       m_done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
